// File: rtl/dly_tap_cal_pkg.sv
// Shared types and constants for the tapped delay-line calibration controller.
package dly_tap_cal_pkg;

    // Default idle cycles before each launch edge.
    localparam int SETTLE_CYC_DEF = 2;

    // Cycles consumed by one sample: settle, launch, two capture cycles, evaluate.
    localparam int SAMP_CYC = SETTLE_CYC_DEF + 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_CAPT   = 3'd3,
        ST_EVAL   = 3'd4,
        ST_FINISH = 3'd5
    } state_t;

    // A sample passes when the captured tap output has caught up with the launched level.
    function automatic logic sample_pass(input logic captured, input logic launched);
        return (captured == launched);
    endfunction

endpackage

// File: rtl/dly_tap_cal_capt.sv
// Two-flop capture of the asynchronous delay-chain tap output.
// The first flop samples DLY_IN on the edge after the launch and is the
// synchronizer stage; the second re-registers it for evaluation.
module dly_tap_cal_capt (
    input  logic CLK,
    input  logic RST,
    input  logic DLY_IN,
    output logic capt_o
);

    (* async_reg = "true" *) logic sync1_q;
    (* async_reg = "true" *) logic sync2_q;
    logic sync1_d;
    logic sync2_d;

    // Next values of the capture pipeline.
    always_comb begin
        sync1_d = DLY_IN;
        sync2_d = sync1_q;
    end

    // Capture and re-register the tap output.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign capt_o = sync2_q;

endmodule

// File: rtl/dly_tap_cal.sv
// Delay-line tap calibration controller: sweeps the tap select upward and
// locks onto the longest tap whose delay still fits in one clock period.
// Optional periodic tracking around the locked tap: define DLY_CAL_TRACK_EN.
module dly_tap_cal
    import dly_tap_cal_pkg::*;
#(
    parameter int NTAPS      = 32,
    parameter int TW         = $clog2(NTAPS),
    parameter int NSAMP      = 4,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF
`ifdef DLY_CAL_TRACK_EN
    ,
    parameter int TRACK_PERIOD = 256
`endif
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    output logic          LAUNCH,
    output logic [TW-1:0] SEL,
    input  logic          DLY_IN,
    output logic          BUSY,
    output logic          DONE,
    output logic [TW-1:0] TAP,
    output logic          LOCK,
    output logic          ERR,
    output logic          SAT
);

    localparam int SW = (NSAMP > 1) ? $clog2(NSAMP) : 1;
    localparam int CW = $clog2(SETTLE_CYC + 2);
    localparam logic [TW-1:0] TAP_MAX     = TW'(NTAPS - 1);
    localparam logic [SW-1:0] SAMP_LAST   = SW'(NSAMP - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] CAPT_LAST   = CW'(1);

    state_t        state_q, state_d;
    logic          launch_q, launch_d;
    logic [TW-1:0] sel_q, sel_d;
    logic [TW-1:0] tap_q, tap_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          lock_q, lock_d;
    logic          err_q, err_d;
    logic          sat_q, sat_d;
    logic [SW-1:0] samp_q, samp_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic          capt_s;
    logic          pass_s;

`ifdef DLY_CAL_TRACK_EN
    localparam int PW = $clog2(TRACK_PERIOD);
    localparam logic [PW-1:0] TMR_LAST = PW'(TRACK_PERIOD - 1);

    logic [PW-1:0] tmr_q, tmr_d;
    logic          trk_q, trk_d;
    logic          phase_q, phase_d;
    logic          up_ok_q, up_ok_d;
`endif

    dly_tap_cal_capt u_capt (
        .CLK    (CLK),
        .RST    (RST),
        .DLY_IN (DLY_IN),
        .capt_o (capt_s)
    );

    assign pass_s = sample_pass(capt_s, launch_q);

    // Next-state and next-output computation for the calibration sequencer.
    always_comb begin
        state_d  = state_q;
        launch_d = launch_q;
        sel_d    = sel_q;
        tap_d    = tap_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        lock_d   = lock_q;
        err_d    = err_q;
        sat_d    = sat_q;
        samp_d   = samp_q;
        cyc_d    = cyc_q;
`ifdef DLY_CAL_TRACK_EN
        tmr_d    = tmr_q;
        trk_d    = trk_q;
        phase_d  = phase_q;
        up_ok_d  = up_ok_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d = ST_SETTLE;
                    sel_d   = '0;
                    samp_d  = '0;
                    cyc_d   = '0;
                    busy_d  = 1'b1;
                    lock_d  = 1'b0;
                    err_d   = 1'b0;
                    sat_d   = 1'b0;
`ifdef DLY_CAL_TRACK_EN
                    trk_d   = 1'b0;
                    tmr_d   = '0;
`endif
                end else begin
`ifdef DLY_CAL_TRACK_EN
                    if (!lock_q) begin
                        tmr_d = '0;
                    end else if (tmr_q == TMR_LAST) begin
                        // Tracking check: probe one tap above the lock, then the lock itself.
                        state_d = ST_SETTLE;
                        trk_d   = 1'b1;
                        phase_d = 1'b0;
                        up_ok_d = 1'b0;
                        busy_d  = 1'b1;
                        samp_d  = '0;
                        cyc_d   = '0;
                        tmr_d   = '0;
                        sel_d   = (tap_q == TAP_MAX) ? tap_q : (tap_q + TW'(1));
                    end else begin
                        tmr_d = tmr_q + PW'(1);
                    end
`else
                    state_d = ST_IDLE;
`endif
                end
            end

            ST_SETTLE: begin
                if (cyc_q == SETTLE_LAST) begin
                    state_d = ST_LAUNCH;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end

            ST_LAUNCH: begin
                launch_d = ~launch_q;
                state_d  = ST_CAPT;
                cyc_d    = '0;
            end

            ST_CAPT: begin
                if (cyc_q == CAPT_LAST) begin
                    state_d = ST_EVAL;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end

            ST_EVAL: begin
`ifdef DLY_CAL_TRACK_EN
                if (trk_q) begin
                    if (pass_s && (samp_q != SAMP_LAST)) begin
                        samp_d  = samp_q + SW'(1);
                        state_d = ST_SETTLE;
                    end else if (!phase_q) begin
                        up_ok_d = pass_s;
                        phase_d = 1'b1;
                        sel_d   = tap_q;
                        samp_d  = '0;
                        state_d = ST_SETTLE;
                    end else begin
                        if (up_ok_q && (tap_q != TAP_MAX)) begin
                            tap_d = tap_q + TW'(1);
                        end else if (!pass_s) begin
                            if (tap_q != '0) begin
                                tap_d = tap_q - TW'(1);
                            end else begin
                                err_d  = 1'b1;
                                lock_d = 1'b0;
                            end
                        end else begin
                            tap_d = tap_q;
                        end
                        trk_d   = 1'b0;
                        state_d = ST_FINISH;
                    end
                end else
`endif
                if (pass_s) begin
                    if (samp_q != SAMP_LAST) begin
                        samp_d  = samp_q + SW'(1);
                        state_d = ST_SETTLE;
                    end else if (sel_q != TAP_MAX) begin
                        sel_d   = sel_q + TW'(1);
                        samp_d  = '0;
                        state_d = ST_SETTLE;
                    end else begin
                        tap_d   = TAP_MAX;
                        sat_d   = 1'b1;
                        lock_d  = 1'b1;
                        state_d = ST_FINISH;
                    end
                end else if (sel_q != '0) begin
                    tap_d   = sel_q - TW'(1);
                    lock_d  = 1'b1;
                    state_d = ST_FINISH;
                end else begin
                    tap_d   = '0;
                    err_d   = 1'b1;
                    lock_d  = 1'b0;
                    state_d = ST_FINISH;
                end
            end

            ST_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                sel_d   = tap_q;
                state_d = ST_IDLE;
`ifdef DLY_CAL_TRACK_EN
                tmr_d   = '0;
`endif
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

`ifdef DLY_CAL_TRACK_EN
        // A new calibration request overrides any tracking check in flight.
        if (trk_q && START) begin
            state_d = ST_SETTLE;
            sel_d   = '0;
            samp_d  = '0;
            cyc_d   = '0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            lock_d  = 1'b0;
            err_d   = 1'b0;
            sat_d   = 1'b0;
            trk_d   = 1'b0;
            tmr_d   = '0;
        end else begin
            trk_d = trk_d;
        end
`endif
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            launch_q <= 1'b0;
            sel_q    <= '0;
            tap_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            lock_q   <= 1'b0;
            err_q    <= 1'b0;
            sat_q    <= 1'b0;
            samp_q   <= '0;
            cyc_q    <= '0;
`ifdef DLY_CAL_TRACK_EN
            tmr_q    <= '0;
            trk_q    <= 1'b0;
            phase_q  <= 1'b0;
            up_ok_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            launch_q <= launch_d;
            sel_q    <= sel_d;
            tap_q    <= tap_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            lock_q   <= lock_d;
            err_q    <= err_d;
            sat_q    <= sat_d;
            samp_q   <= samp_d;
            cyc_q    <= cyc_d;
`ifdef DLY_CAL_TRACK_EN
            tmr_q    <= tmr_d;
            trk_q    <= trk_d;
            phase_q  <= phase_d;
            up_ok_q  <= up_ok_d;
`endif
        end
    end

    assign LAUNCH = launch_q;
    assign SEL    = sel_q;
    assign TAP    = tap_q;
    assign BUSY   = busy_q;
    assign DONE   = done_q;
    assign LOCK   = lock_q;
    assign ERR    = err_q;
    assign SAT    = sat_q;

endmodule

// File: tb/tb_dly_tap_cal.sv
// Testbench for dly_tap_cal: behavioural delay-chain model plus a reference
// model that predicts the calibration result from the per-tap delays.
`timescale 1ns/1ps
module tb_dly_tap_cal;

    localparam int  NTAPS  = 32;
    localparam int  NSAMP  = 4;
    localparam real PERIOD = 10.0;

    logic       CLK    = 1'b0;
    logic       RST    = 1'b1;
    logic       START  = 1'b0;
    logic       DLY_IN = 1'b0;
    logic       LAUNCH;
    logic [4:0] SEL;
    logic       BUSY;
    logic       DONE;
    logic [4:0] TAP;
    logic       LOCK;
    logic       ERR;
    logic       SAT;

    int  n_chk  = 0;
    int  n_fail = 0;
    real tap_dly [NTAPS];

    dly_tap_cal dut (
        .CLK    (CLK),
        .RST    (RST),
        .START  (START),
        .LAUNCH (LAUNCH),
        .SEL    (SEL),
        .DLY_IN (DLY_IN),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .TAP    (TAP),
        .LOCK   (LOCK),
        .ERR    (ERR),
        .SAT    (SAT)
    );

    always #5 CLK = ~CLK;

    // Delay chain: every LAUNCH edge reappears on DLY_IN after the selected tap delay.
    task automatic chain_edge(input logic v, input real d);
        fork
            begin
                #(d);
                DLY_IN = v;
            end
        join_none
    endtask

    always @(LAUNCH) chain_edge(LAUNCH, tap_dly[SEL]);

    task automatic check_val(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Delay profile: a fixed routing offset plus a per-tap increment; keep clear of the clock edge.
    task automatic set_profile(input real offs, input real step);
        for (int k = 0; k < NTAPS; k++) begin
            tap_dly[k] = offs + step * real'(k + 1);
            if (tap_dly[k] > PERIOD - 0.3 && tap_dly[k] < PERIOD + 0.3)
                tap_dly[k] = tap_dly[k] + 0.6;
        end
    endtask

    // Reference: the first tap whose delay does not fit in a period ends the sweep.
    task automatic model(output int e_tap, output int e_lock, output int e_err,
                         output int e_sat, output int e_cyc);
        int f;
        f = -1;
        for (int k = 0; k < NTAPS; k++)
            if (f < 0 && tap_dly[k] >= PERIOD) f = k;
        e_err = 0; e_sat = 0; e_lock = 1;
        if (f == 0) begin
            e_tap = 0; e_err = 1; e_lock = 0; e_cyc = 7;
        end else if (f < 0) begin
            e_tap = NTAPS - 1; e_sat = 1; e_cyc = NTAPS * NSAMP * 6 + 1;
        end else begin
            e_tap = f - 1; e_cyc = f * NSAMP * 6 + 7;
        end
    endtask

    // Run one calibration; optionally pulse START again at cycle restart_at.
    task automatic run_cal(input string nm, input int restart_at);
        int e_tap, e_lock, e_err, e_sat, e_cyc;
        int cyc;
        logic got;
        model(e_tap, e_lock, e_err, e_sat, e_cyc);
        @(negedge CLK) START = 1'b1;
        @(posedge CLK);
        #1;
        check_val({nm, " busy_after_start"}, int'(BUSY), 1);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 2000) begin
            @(negedge CLK) START = (cyc == restart_at);
            @(posedge CLK);
            cyc++;
            #1;
            if (DONE) got = 1'b1;
        end
        START = 1'b0;
        check_val({nm, " done_seen"}, int'(got), 1);
        check_val({nm, " cycles"}, cyc, e_cyc);
        check_val({nm, " tap"}, int'(TAP), e_tap);
        check_val({nm, " lock"}, int'(LOCK), e_lock);
        check_val({nm, " err"}, int'(ERR), e_err);
        check_val({nm, " sat"}, int'(SAT), e_sat);
        check_val({nm, " busy_at_done"}, int'(BUSY), 0);
        check_val({nm, " sel_eq_tap"}, int'(SEL), e_tap);
        @(posedge CLK);
        #1;
        check_val({nm, " done_pulse"}, int'(DONE), 0);
        repeat (10) @(posedge CLK);
    endtask

    initial begin
        int   lev;
        int   n;
        logic seen;
        set_profile(0.5, 1.0);

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        check_val("rst launch", int'(LAUNCH), 0);
        check_val("rst sel", int'(SEL), 0);
        check_val("rst tap", int'(TAP), 0);
        check_val("rst busy", int'(BUSY), 0);
        check_val("rst done", int'(DONE), 0);
        check_val("rst lock", int'(LOCK), 0);
        check_val("rst err", int'(ERR), 0);
        check_val("rst sat", int'(SAT), 0);
        @(negedge CLK) RST = 1'b0;
        repeat (2) @(posedge CLK);

        // Nominal chain: 1 ns per tap, tap 8 is the last that fits
        set_profile(0.5, 1.0);
        run_cal("nominal", -1);
        check_val("nominal tap8", int'(TAP), 8);

`ifdef DLY_CAL_TRACK_EN
        // Chain speeds up: tracking should move the lock up by one tap
        set_profile(0.5, 0.9);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 256 + 200) begin
            @(posedge CLK);
            n++;
            #1;
            if (DONE) seen = 1'b1;
        end
        check_val("track done_seen", int'(seen), 1);
        check_val("track tap", int'(TAP), 9);
        check_val("track lock", int'(LOCK), 1);
        repeat (4) @(posedge CLK);
        set_profile(0.5, 1.0);
`endif

        // Tap 0 already too slow
        set_profile(11.0, 1.0);
        run_cal("tap0_fail", -1);

        // Every tap fits
        set_profile(0.3, 0.2);
        run_cal("saturate", -1);

        // Random chain speeds
        for (int i = 0; i < 6; i++) begin
            set_profile(0.5, real'($urandom_range(80, 1400)) / 1000.0);
            run_cal($sformatf("rand%0d", i), -1);
        end

        // START while busy is dropped
        set_profile(0.5, 1.0);
        run_cal("restart_ignored", 50);

        // Reset during capture while sweeping tap 5
        run_cal("pre_rst", -1);
        @(negedge CLK) START = 1'b1;
        @(negedge CLK) START = 1'b0;
        n = 0;
        while (SEL != 5'd5 && n < 1000) begin
            @(posedge CLK);
            n++;
            #1;
        end
        check_val("rst_mid sel_reached", int'(SEL), 5);
        lev = int'(LAUNCH);
        n = 0;
        while (int'(LAUNCH) == lev && n < 20) begin
            @(posedge CLK);
            n++;
            #1;
        end
        check_val("rst_mid launch_toggled", int'(LAUNCH), 1 - lev);
        @(posedge CLK);
        @(negedge CLK) RST = 1'b1;
        @(posedge CLK);
        #1;
        check_val("rst_mid sel", int'(SEL), 0);
        check_val("rst_mid launch", int'(LAUNCH), 0);
        check_val("rst_mid busy", int'(BUSY), 0);
        check_val("rst_mid done", int'(DONE), 0);
        @(negedge CLK) RST = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK);
            #1;
            if (DONE || BUSY) seen = 1'b1;
        end
        check_val("rst_mid no_done", int'(seen), 0);

        // START together with RST stays idle
        @(negedge CLK) begin
            RST   = 1'b1;
            START = 1'b1;
        end
        @(negedge CLK) begin
            RST   = 1'b0;
            START = 1'b0;
        end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK);
            #1;
            if (BUSY || DONE) seen = 1'b1;
        end
        check_val("rst_start idle", int'(seen), 0);

        // Calibration still works after the reset
        set_profile(0.5, 1.0);
        run_cal("post_rst", -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
